axi_wr_bank: RTL

AXI_WR_BANK -- requirements
Module: axi_wr_bank

---
 rtl/mbank_pkg.sv | 20 ++
 rtl/wr_bank_mem.sv | 58 +++++
 rtl/axi_wr_bank.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mbank_pkg.sv
// Shared types and defaults for the AXI4-Lite write bank.
package mbank_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GOT_AW = 3'd1,
        GOT_W  = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } wr_state_t;

endpackage

// File: rtl/wr_bank_mem.sv
// Bank storage with a registered read-back port.
// Compile-time option WR_BYPASS_EN: when defined, a read of the word being
// written on the same edge returns the new data (write-first); otherwise it
// returns the old contents (read-first).
module wr_bank_mem
    import mbank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Next memory contents and next read-back value, including the same-edge bypass choice.
    always_comb begin
        mem_d   = mem_q;
        rdata_d = rdata_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
        if (ren) begin
`ifdef WR_BYPASS_EN
            rdata_d = mem_d[raddr];
`else
            rdata_d = mem_q[raddr];
`endif
        end
    end

    // Storage and read-back register; reset clears every word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_wr_bank.sv
// AXI4-Lite write slave in front of a small word bank, with a side read-back port.
// Compile-time option WR_BYPASS_EN selects write-first read-back (see wr_bank_mem).
module axi_wr_bank
    import mbank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [ADDR_W-1:0]        awaddr,
    input  logic                     wvalid,
    output logic                     wready,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     wstrb,
    output logic                     bvalid,
    input  logic                     bready,
    output logic [1:0]               bresp,
    input  logic                     ren,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    wr_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              strb_q, strb_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    resp_t             bresp_q, bresp_d;

    logic aw_hs;
    logic w_hs;
    logic in_range;
    logic mem_we;

    assign aw_hs    = awvalid && awready_q;
    assign w_hs     = wvalid && wready_q;
    assign in_range = (addr_q < DEPTH_A);
    assign mem_we   = (state_q == WRITE) && in_range && strb_q;

    // Next-state, latch and registered-output decode for the write handshake FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        strb_d  = strb_q;
        bresp_d = bresp_q;
        if (aw_hs) begin
            addr_d = awaddr;
        end
        if (w_hs) begin
            data_d = wdata;
            strb_d = wstrb;
        end
        case (state_q)
            IDLE: begin
                if (aw_hs && w_hs) begin
                    state_d = WRITE;
                end else if (aw_hs) begin
                    state_d = GOT_AW;
                end else if (w_hs) begin
                    state_d = GOT_W;
                end
            end
            GOT_AW: begin
                if (w_hs) begin
                    state_d = WRITE;
                end
            end
            GOT_W: begin
                if (aw_hs) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = RESP;
                bresp_d = in_range ? OKAY : SLVERR;
            end
            RESP: begin
                if (bready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        awready_d = (state_d == IDLE) || (state_d == GOT_W);
        wready_d  = (state_d == IDLE) || (state_d == GOT_AW);
        bvalid_d  = (state_d == RESP);
    end

    // FSM state, latched request and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

    wr_bank_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (addr_q[IDX_W-1:0]),
        .wdata (data_q),
        .ren   (ren),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule
